arp_resolve_ctrl: RTL and testbench

- Sequences MAC resolution for the UDP transmit path in front of the single-entry ARP cache.
- On a send request it presents the destination IP to the cache and waits for the registered lookup.
- On a miss it issues ARP requests through the ARP TX engine, waits for a reply or a timeout, and retries a bounded number of times.
- It then grants the send with the resolved MAC, or reports failure.

---
 rtl/arp_resolve_ctrl_if.sv | 49 ++++
 rtl/arp_resolve_ctrl.sv | 141 ++++++++++++++
 tb/tb_arp_resolve_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_resolve_ctrl_if.sv
// Bundle between the ARP resolve controller and the UDP TX path,
// the single-entry ARP cache and the ARP TX engine.
interface arp_resolve_ctrl_if;
  logic        udp_send_req;
  logic [31:0] dest_ip;
  logic [31:0] cache_dest_ip;
  logic [47:0] cache_mac;
  logic        cache_mac_not_exist;
  logic        arp_found;
  logic        arp_tx_busy;
  logic        arp_req_start;
  logic [31:0] arp_req_target_ip;
  logic [47:0] udp_dest_mac;
  logic        udp_send_grant;
  logic        udp_send_fail;
  logic        busy;

  modport slave (
    input  udp_send_req,
    input  dest_ip,
    input  cache_mac,
    input  cache_mac_not_exist,
    input  arp_found,
    input  arp_tx_busy,
    output cache_dest_ip,
    output arp_req_start,
    output arp_req_target_ip,
    output udp_dest_mac,
    output udp_send_grant,
    output udp_send_fail,
    output busy
  );

  modport master (
    output udp_send_req,
    output dest_ip,
    output cache_mac,
    output cache_mac_not_exist,
    output arp_found,
    output arp_tx_busy,
    input  cache_dest_ip,
    input  arp_req_start,
    input  arp_req_target_ip,
    input  udp_dest_mac,
    input  udp_send_grant,
    input  udp_send_fail,
    input  busy
  );
endinterface

// File: rtl/arp_resolve_ctrl.sv
// MAC resolution sequencer: cache lookup, bounded ARP retries,
// then grant with the resolved MAC or report failure.
module arp_resolve_ctrl #(
  parameter int CACHE_LAT      = 2,
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int MAX_RETRY      = 3
) (
  input logic             clk,
  input logic             rst_n,
  arp_resolve_ctrl_if.slave bus
);

  localparam int WW = $clog2(CACHE_LAT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WW-1:0] WAIT_LAST = WW'(CACHE_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    ARP_REQ,
    ARP_WAIT,
    DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    retry_q;
  logic [WW-1:0] wait_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   cache_ip_q;
  logic [31:0]   target_q;
  logic [47:0]   mac_q;
  logic          start_q;
  logic          grant_q;
  logic          fail_q;
  logic          busy_q;

  assign bus.cache_dest_ip     = cache_ip_q;
  assign bus.arp_req_target_ip = target_q;
  assign bus.udp_dest_mac      = mac_q;
  assign bus.arp_req_start     = start_q;
  assign bus.udp_send_grant    = grant_q;
  assign bus.udp_send_fail     = fail_q;
  assign bus.busy              = busy_q;

  // Resolution FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      wait_q     <= '0;
      timer_q    <= '0;
      cache_ip_q <= '0;
      target_q   <= '0;
      mac_q      <= '1;
      start_q    <= 1'b0;
      grant_q    <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      grant_q <= 1'b0;
      fail_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.udp_send_req) begin
            cache_ip_q <= bus.dest_ip;
            target_q   <= bus.dest_ip;
            retry_q    <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!bus.udp_send_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= CHECK;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        CHECK: begin
          if (!bus.udp_send_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!bus.cache_mac_not_exist) begin
            mac_q   <= bus.cache_mac;
            grant_q <= 1'b1;
            state_q <= DONE;
          end else if (retry_q == RETRY_MAX) begin
            fail_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ARP_REQ;
          end
        end
        ARP_REQ: begin
          if (!bus.udp_send_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!bus.arp_tx_busy) begin
            start_q <= 1'b1;
            retry_q <= retry_q + 4'd1;
            timer_q <= '0;
            state_q <= ARP_WAIT;
          end
        end
        ARP_WAIT: begin
          // A reply for any IP triggers a re-lookup without
          // spending a retry; the cache check sorts it out.
          if (!bus.udp_send_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.arp_found || timer_q == TMO_LAST) begin
            wait_q  <= '0;
            state_q <= LOOKUP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          if (!bus.udp_send_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_resolve_ctrl.sv
// Randomized scoreboard bench for arp_resolve_ctrl with a
// behavioural ARP cache and reply model.
module tb_arp_resolve_ctrl;

  localparam int CL    = 2;
  localparam int TO    = 50;
  localparam int MR    = 3;
  localparam int BOUND = MR * (TO + CL + 12) + 60;

  typedef struct {
    bit          is_grant;
    logic [47:0] mac;
    int          starts;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arp_resolve_ctrl_if bus();

  arp_resolve_ctrl #(
    .CACHE_LAT(CL),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Environment: single-entry cache with CL-clock registered lookup.
  logic        c_valid = 1'b0;
  logic [31:0] c_ip = '0;
  logic [47:0] c_mac = '0;
  logic [31:0] found_ip;
  logic [47:0] found_mac;
  logic [48:0] p1 = {1'b1, 48'h0};
  logic [48:0] p2 = {1'b1, 48'h0};

  always @(posedge clk) begin
    if (bus.arp_found) begin
      c_valid <= 1'b1;
      c_ip    <= found_ip;
      c_mac   <= found_mac;
    end
    p1 <= (c_valid && c_ip == bus.cache_dest_ip) ?
          {1'b0, c_mac} : {1'b1, 48'h0};
    p2 <= p1;
  end

  assign bus.cache_mac           = p2[47:0];
  assign bus.cache_mac_not_exist = p2[48];

  logic force_busy = 1'b0;
  logic rand_busy = 1'b0;
  bit   rand_en = 1'b1;
  assign bus.arp_tx_busy = force_busy | rand_busy;

  initial forever begin
    @(negedge clk);
    rand_busy = rand_en && ($urandom_range(0, 3) == 0);
  end

  // Reference model state.
  bit          m_valid;
  logic [31:0] m_ip;
  logic [47:0] m_mac;
  logic [47:0] last_mac;
  logic [31:0] cur_ip;

  int          resp[MR];
  logic [47:0] rmac[MR];
  logic [31:0] fip[MR];

  logic [31:0] ips[4] = '{32'hC0A8010A, 32'hC0A80105,
                          32'hC0A80199, 32'hC0A80177};

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cache_ip"}, 64'(bus.cache_dest_ip), 64'h0);
    chk({tag, "_target"}, 64'(bus.arp_req_target_ip), 64'h0);
    chk({tag, "_mac"}, 64'(bus.udp_dest_mac), 64'hffffffffffff);
    chk({tag, "_start"}, 64'(bus.arp_req_start), 64'h0);
    chk({tag, "_grant"}, 64'(bus.udp_send_grant), 64'h0);
    chk({tag, "_fail"}, 64'(bus.udp_send_fail), 64'h0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
  endtask

  // Monitor: pops the scoreboard on each grant/fail pulse.
  int   starts_seen = 0;
  logic busy_smp = 1'b0;
  always @(posedge clk) busy_smp <= bus.arp_tx_busy;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!bus.busy) starts_seen = 0;
      if (bus.arp_req_start) begin
        starts_seen++;
        chk("arp_target", 64'(bus.arp_req_target_ip), 64'(cur_ip));
        chk("start_while_tx_busy", 64'(busy_smp), 64'h0);
      end
      if (bus.udp_send_grant || bus.udp_send_fail) begin
        chk("grant_fail_excl",
            64'(bus.udp_send_grant & bus.udp_send_fail), 64'h0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 64'(sb.size() != 0), 64'h1);
        end else begin
          e = sb.pop_front();
          chk("outcome_grant", 64'(bus.udp_send_grant),
              64'(e.is_grant));
          chk("arp_starts", 64'(starts_seen), 64'(e.starts));
          chk("udp_dest_mac", 64'(bus.udp_dest_mac), 64'(e.mac));
        end
      end
    end
  end

  task automatic plan_random(input logic [31:0] ip);
    logic [63:0] r;
    for (int i = 0; i < MR; i++) begin
      resp[i] = $urandom_range(0, 2);
      r = {$urandom, $urandom};
      rmac[i] = r[47:0];
      fip[i] = ip;
      while (fip[i] == ip) fip[i] = ips[$urandom_range(0, 3)];
    end
  endtask

  // mode 0: normal, 1: withdraw in ARP_WAIT, 2: reset in ARP_WAIT
  task automatic txn(input logic [31:0] ip, input int mode,
                     input int bforce);
    exp_t e;
    bit   hit, done;
    int   cyc, k, reply_at, rk, last_start;
    hit = m_valid && m_ip == ip;
    if (mode == 0) begin
      e.is_grant = 1'b0;
      e.mac = last_mac;
      e.starts = MR;
      if (hit) begin
        e.is_grant = 1'b1;
        e.mac = m_mac;
        e.starts = 0;
      end else begin
        for (int i = 0; i < MR; i++) begin
          if (resp[i] == 1) begin
            e.is_grant = 1'b1;
            e.mac = rmac[i];
            e.starts = i + 1;
            m_valid = 1'b1;
            m_ip = ip;
            m_mac = rmac[i];
            break;
          end
          if (resp[i] == 2) begin
            m_valid = 1'b1;
            m_ip = fip[i];
            m_mac = rmac[i];
          end
        end
      end
      last_mac = e.mac;
      sb.push_back(e);
    end
    cur_ip = ip;
    bus.udp_send_req = 1'b1;
    bus.dest_ip = ip;
    force_busy = (bforce > 0);
    cyc = 0;
    k = 0;
    rk = 0;
    reply_at = -1;
    last_start = 0;
    done = 1'b0;
    while (!done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      bus.dest_ip = $urandom;
      bus.arp_found = 1'b0;
      if (bforce > 0 && cyc == bforce) force_busy = 1'b0;
      if (bus.udp_send_grant || bus.udp_send_fail) begin
        done = 1'b1;
        if (mode == 0 && hit) chk("hit_latency", 64'(cyc), 64'(CL + 2));
      end else if (bus.arp_req_start) begin
        if (bforce > 0) chk("start_after_busy", 64'(cyc > bforce), 64'h1);
        if (!rand_en && k > 0 && resp[k-1] == 0)
          chk("retry_spacing", 64'(cyc - last_start), 64'(TO + CL + 2));
        last_start = cyc;
        if (mode == 1) begin
          repeat (5) @(negedge clk);
          bus.udp_send_req = 1'b0;
          @(negedge clk);
          chk("abort_busy", 64'(bus.busy), 64'h0);
          repeat (3) @(negedge clk);
          return;
        end
        if (mode == 2) begin
          repeat (3) @(negedge clk);
          #2 rst_n = 1'b0;
          #1 chk_reset("midreset");
          last_mac = '1;
          @(negedge clk);
          bus.udp_send_req = 1'b0;
          rst_n = 1'b1;
          @(negedge clk);
          return;
        end
        if (k < MR && resp[k] != 0) begin
          reply_at = cyc + $urandom_range(1, TO - 4);
          rk = k;
        end
        k++;
      end else if (cyc == reply_at) begin
        bus.arp_found = 1'b1;
        found_ip = (resp[rk] == 1) ? ip : fip[rk];
        found_mac = rmac[rk];
      end
    end
    chk("txn_completed", 64'(done), 64'h1);
    bus.udp_send_req = 1'b0;
    bus.arp_found = 1'b0;
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_after_drop", 64'(bus.busy), 64'h0);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ip;
    bus.udp_send_req = 1'b0;
    bus.dest_ip = '0;
    bus.arp_found = 1'b0;
    found_ip = '0;
    found_mac = '0;
    m_valid = 1'b0;
    m_ip = '0;
    m_mac = '0;
    last_mac = '1;
    cur_ip = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    rand_en = 1'b0;
    resp = '{0, 0, 0};
    txn(32'hC0A80177, 0, 0);
    rand_en = 1'b1;

    bus.arp_found = 1'b1;
    found_ip = 32'hC0A8010A;
    found_mac = 48'h021122334455;
    @(negedge clk);
    bus.arp_found = 1'b0;
    m_valid = 1'b1;
    m_ip = 32'hC0A8010A;
    m_mac = 48'h021122334455;
    chk("idle_ignores_found", 64'(bus.busy), 64'h0);
    @(negedge clk);

    txn(32'hC0A8010A, 0, 0);

    resp = '{1, 0, 0};
    rmac[0] = 48'h0A0B0C0D0E0F;
    txn(32'hC0A80105, 0, 0);

    resp = '{2, 1, 0};
    fip[0] = 32'hC0A80199;
    rmac[0] = 48'h00AA00BB00CC;
    rmac[1] = 48'h0266778899AA;
    txn(32'hC0A80177, 0, 0);

    resp = '{1, 0, 0};
    rmac[0] = 48'h02DEADBEEF01;
    txn(32'hC0A8010A, 0, 10);

    txn(32'hC0A80199, 1, 0);

    for (int n = 0; n < 30; n++) begin
      ip = ips[$urandom_range(0, 3)];
      plan_random(ip);
      txn(ip, 0,
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : 0);
    end

    ip = (m_ip == 32'hC0A80199) ? 32'hC0A80105 : 32'hC0A80199;
    txn(ip, 2, 0);

    plan_random(ip);
    resp[0] = 1;
    txn(ip, 0, 0);
    txn(ip, 0, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
